// File: rtl/right_shifter_n_bit_pkg.sv
// Shared ALU definitions: condition-flag bit positions and the flags word type.
package right_shifter_n_bit_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/right_shifter_comb.sv
// Combinational logical right shift with carry-out of the last bit shifted out.
module right_shifter_comb #(
  parameter int unsigned N       = 8,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic [N-1:0]       in_a,
  input  logic [SHIFT_W-1:0] shift,
  output logic [N-1:0]       result,
  output logic               carry
);

  int unsigned amt;

  // Amounts of N or more clear the result; carry is in_a[shift-1] up to shift == N.
  always_comb begin
    amt    = 32'(shift);
    result = '0;
    carry  = 1'b0;
    if (amt < N) begin
      result = in_a >> amt;
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (amt == i + 1) begin
        carry = in_a[i];
      end
    end
  end

endmodule

// File: rtl/right_shifter_n_bit.sv
// Registered N-bit logical right shifter with N/Z/V/C condition flags.
module right_shifter_n_bit
  import right_shifter_n_bit_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_a,
  input  logic [SHIFT_W-1:0] shift,
  output logic [N-1:0]       out,
  output logic [3:0]         flags_n_z_v_c
);

  logic [N-1:0] result;
  logic         carry;
  alu_flags_t   flags_d;

  right_shifter_comb #(
    .N       (N),
    .SHIFT_W (SHIFT_W)
  ) u_comb (
    .in_a   (in_a),
    .shift  (shift),
    .result (result),
    .carry  (carry)
  );

  // Flags derived from the same-cycle result; overflow never occurs for a shift.
  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_N] = result[N-1];
    flags_d[FLAG_Z] = (result == '0);
    flags_d[FLAG_V] = 1'b0;
    flags_d[FLAG_C] = carry;
  end

  // Output register; reset clears everything, including Z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out           <= '0;
      flags_n_z_v_c <= '0;
    end else begin
      out           <= result;
      flags_n_z_v_c <= flags_d;
    end
  end

endmodule

// File: tb/tb_right_shifter_n_bit.sv
// Directed test of the registered right shifter: reset, shifts, boundaries, back-to-back.
module tb_right_shifter_n_bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_a;
  logic [3:0] shift;
  logic [7:0] out;
  logic [3:0] flags_n_z_v_c;

  int checks = 0;
  int errors = 0;

  right_shifter_n_bit #(
    .N       (8),
    .SHIFT_W (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_a          (in_a),
    .shift         (shift),
    .out           (out),
    .flags_n_z_v_c (flags_n_z_v_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp_out, input logic [3:0] exp_flags);
    checks++;
    assert (out === exp_out) else begin
      errors++;
      $error("FAIL %s out got %h expected %h", tag, out, exp_out);
    end
    checks++;
    assert (flags_n_z_v_c === exp_flags) else begin
      errors++;
      $error("FAIL %s flags got %b expected %b", tag, flags_n_z_v_c, exp_flags);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [7:0] a, input logic [3:0] s,
                      input logic [7:0] exp_out, input logic [3:0] exp_flags);
    @(negedge clk);
    in_a  = a;
    shift = s;
    @(posedge clk);
    #1;
    check(tag, exp_out, exp_flags);
  endtask

  initial begin
    rst_n = 1'b0;
    in_a  = 8'hF0;
    shift = 4'd1;
    #1;
    check("reset_async", 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_hold", 8'h00, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 8'h00, 4'b0000);

    step("f0_s1",  8'hF0, 4'd1,  8'h78, 4'b0000);
    step("f0_s3",  8'hF0, 4'd3,  8'h1E, 4'b0000);
    step("f0_s6",  8'hF0, 4'd6,  8'h03, 4'b0001);
    step("f0_s0",  8'hF0, 4'd0,  8'hF0, 4'b1000);
    step("0f_s4",  8'h0F, 4'd4,  8'h00, 4'b0101);
    step("80_s7",  8'h80, 4'd7,  8'h01, 4'b0000);
    step("80_s8",  8'h80, 4'd8,  8'h00, 4'b0101);
    step("80_s15", 8'h80, 4'd15, 8'h00, 4'b0100);
    step("ff_s9",  8'hFF, 4'd9,  8'h00, 4'b0100);
    step("01_s1",  8'h01, 4'd1,  8'h00, 4'b0101);
    step("00_s0",  8'h00, 4'd0,  8'h00, 4'b0100);

    step("b2b_s1", 8'hFF, 4'd1, 8'h7F, 4'b0001);
    step("b2b_s2", 8'hFF, 4'd2, 8'h3F, 4'b0001);
    step("b2b_s3", 8'hFF, 4'd3, 8'h1F, 4'b0001);

    @(negedge clk);
    in_a  = 8'hF0;
    shift = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_mid_hold", 8'h00, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_mid_release", 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    check("first_after_reset", 8'hF0, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
